tlul_host_arbiter: RTL and testbench
====================================

# tlul_host_arbiter

Parametrised N-host to 1-device TL-UL arbiter for the main interconnect. It lets several masters share one TL-UL device port, such as a scratchpad or UART: management-core instruction and data ports, DMA, and future cluster cores. Requests are arbitrated round-robin with grant locking. An in-order routing FIFO of granted host indices steers device responses back to the originating host. This generalises the fixed 2-master point-to-point hookup to NumHosts masters with bounded outstanding transactions and error reporting.

## Interface
- NumHosts, default 2: number of host ports, range 1..16.
- MaxOutstanding, default 4: depth of the response-routing FIFO, range 1..16, power of two.
- HostIdxW, derived: $clog2(NumHosts), minimum 1.
- clk_i  in  1  clock; the only clock.
- rst_ni  in  1  reset, synchronous, active-low.
- tl_h_i  in  tl_h2d_t [NumHosts]  host A-channel requests and D-channel d_ready.
- tl_h_o  out  tl_d2h_t [NumHosts]  host D-channel responses and A-channel a_ready.
- tl_d_o  out  tl_h2d_t  device-side request.
- tl_d_i  in  tl_d2h_t  device-side response.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current FIFO occupancy.
- err_unexp_rsp_o  out  1  sticky flag: a device d_valid arrived with no outstanding request.

## Operation
- State:
  - grant index gnt_q (HostIdxW bits).
  - lock bit lock_q.
  - round-robin pointer rr_q (HostIdxW bits).
  - routing FIFO of HostIdxW-bit entries with wrap-around read/write pointers and a count.
  - sticky error bit.
- Arbitration, when lock_q=0:
  - gnt is the first host i with tl_h_i[i].a_valid=1, searching rr_q, rr_q+1, … with modulo-NumHosts wrap.
  - If no host is valid, there is no grant and tl_d_o.a_valid=0.
- Arbitration, when lock_q=1: gnt=gnt_q, held unconditionally.
- Lock rules:
  - Set lock_q and capture gnt_q when tl_d_o.a_valid=1 and tl_d_i.a_ready=0.
  - Clear lock_q on the A handshake.
  - This keeps A-channel fields stable while a_valid is high, as TL-UL requires.
- A path:
  - tl_d_o carries host[gnt] A fields unchanged, including a_source.
  - tl_d_o.a_valid = host[gnt].a_valid & ~fifo_full.
  - tl_h_o[gnt].a_ready = tl_d_i.a_ready & ~fifo_full; a_ready is 0 for all other hosts.
- On A handshake:
  - push gnt into the FIFO.
  - rr_q ← gnt+1 modulo NumHosts.
- D path, FIFO non-empty:
  - head = FIFO head entry.
  - tl_h_o[head].d_valid = tl_d_i.d_valid; d_valid is 0 for all other hosts.
  - D fields are broadcast to all hosts.
  - tl_d_o.d_ready = tl_h_i[head].d_ready.
  - Pop on tl_d_i.d_valid & tl_d_o.d_ready.
- D path, FIFO empty:
  - tl_d_o.d_ready=1; the response is drained and dropped.
  - No host sees d_valid.
  - err_unexp_rsp_o is set if tl_d_i.d_valid=1.
- Response order: the device must respond in request order. Out-of-order devices are not supported.
- FIFO full: no new A handshake. A pending locked grant stays locked and a_valid is deasserted until a pop frees an entry. No push bypass when full.
- Simultaneous push and pop: legal at any occupancy below full; count is unchanged and both pointers advance with wrap.
- Reset, rst_ni=0 at a clock edge:
  - FIFO emptied; gnt_q, lock_q, rr_q and error cleared.
  - While rst_ni=0, tl_d_o.a_valid, tl_d_o.d_ready, and all host a_ready/d_valid are forced 0.
  - In-flight transactions are abandoned. Responses arriving after release of reset set err_unexp_rsp_o.

## Timing
- A path and D path are combinational: zero added latency.
- Grant: same cycle as a_valid when unlocked.
- State updates on the rising clk_i edge.
- Reset values: outstanding_o=0, err_unexp_rsp_o=0. All valid/ready outputs are 0 during reset. First grant is possible in the first cycle after rst_ni=1.
- Throughput: one request per cycle.
- After a full-FIFO stall, A resumes the cycle after the pop edge.
- A-handshake side effects are visible one cycle later: outstanding_o and rr_q update on the same edge.
- err_unexp_rsp_o rises the cycle after the offending d_valid and clears only on reset.

## Test plan
- NumHosts=3, all hosts assert a_valid continuously, device always ready -> grants cycle 0,1,2,0,1,2; every host's D response is returned to that host in order.
- Host 1 a_valid, device a_ready=0 for 3 cycles while host 0 also raises a_valid -> grant stays on host 1 (lock) with stable fields; host 0 is granted on the cycle after host 1's handshake.
- MaxOutstanding=4, device withholds d_valid -> 4 A handshakes, then a_valid=0 and outstanding_o=4; one response -> outstanding_o=3 and the fifth request is accepted next cycle.
- Push and pop in the same cycle at occupancy 2 for 10 cycles -> outstanding_o stays 2; pointers wrap with no misrouting.
- Device drives d_valid with an empty FIFO -> d_ready=1, no host d_valid, err_unexp_rsp_o=1 the next cycle and it remains 1.
- Reset asserted with 3 outstanding requests -> outstanding_o=0 and err=0 after the edge; all valid/ready outputs are 0 while rst_ni=0.

Source files
------------

// File: rtl/tlul_host_arbiter_if.sv
// TL-UL link bundle carrying NumLanes parallel ports: A channel host->device, D channel device->host.
// The arbiter sees the host side through the slave modport and the device side through master.
interface tlul_host_arbiter_if #(
  parameter int NumLanes = 1
);
  logic [NumLanes-1:0]       a_valid;
  logic [NumLanes-1:0][2:0]  a_opcode;
  logic [NumLanes-1:0][1:0]  a_size;
  logic [NumLanes-1:0][7:0]  a_source;
  logic [NumLanes-1:0][31:0] a_address;
  logic [NumLanes-1:0][3:0]  a_mask;
  logic [NumLanes-1:0][31:0] a_data;
  logic [NumLanes-1:0]       a_ready;
  logic [NumLanes-1:0]       d_valid;
  logic [NumLanes-1:0][2:0]  d_opcode;
  logic [NumLanes-1:0][1:0]  d_size;
  logic [NumLanes-1:0][7:0]  d_source;
  logic [NumLanes-1:0][31:0] d_data;
  logic [NumLanes-1:0]       d_error;
  logic [NumLanes-1:0]       d_ready;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_data, d_error
  );
endinterface

// File: rtl/tlul_host_arbiter.sv
// N-host to 1-device TL-UL arbiter: round-robin grant with lock-until-handshake,
// and an in-order FIFO of granted host indices that steers D responses back.
module tlul_host_arbiter #(
  parameter int  NumHosts       = 2,
  parameter int  MaxOutstanding = 4,
  localparam int HostIdxW       = (NumHosts > 1) ? $clog2(NumHosts) : 1,
  localparam int PtrW           = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1,
  localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  tlul_host_arbiter_if.slave  tl_h,
  tlul_host_arbiter_if.master tl_d,
  output logic [CntW-1:0]     outstanding_o,
  output logic                err_unexp_rsp_o
);

  logic [HostIdxW-1:0] gnt_reg, gnt_next;
  logic [HostIdxW-1:0] rr_reg, rr_next;
  logic                lock_reg, lock_next;
  logic [PtrW-1:0]     wptr_reg, wptr_next;
  logic [PtrW-1:0]     rptr_reg, rptr_next;
  logic [CntW-1:0]     cnt_reg, cnt_next;
  logic                err_reg, err_next;

  // Head entry must steer D in the same cycle, so the array is read combinationally.
  logic [HostIdxW-1:0] fifo_mem [MaxOutstanding];

  logic [HostIdxW-1:0] arb_idx, gnt, head;
  logic                arb_found, gnt_valid;
  logic                fifo_full, fifo_empty;
  logic                dev_a_valid, dev_d_ready, a_hs, d_pop;

  function automatic logic [HostIdxW-1:0] host_wrap(logic [HostIdxW-1:0] base, int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NumHosts) sum = sum - NumHosts;
    return HostIdxW'(sum);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MaxOutstanding - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gnt_reg  <= '0;
      rr_reg   <= '0;
      lock_reg <= 1'b0;
      wptr_reg <= '0;
      rptr_reg <= '0;
      cnt_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      gnt_reg  <= gnt_next;
      rr_reg   <= rr_next;
      lock_reg <= lock_next;
      wptr_reg <= wptr_next;
      rptr_reg <= rptr_next;
      cnt_reg  <= cnt_next;
      err_reg  <= err_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (a_hs) fifo_mem[wptr_reg] <= gnt;
  end

  always_comb begin
    lock_next = lock_reg;
    gnt_next  = gnt_reg;
    rr_next   = rr_reg;
    wptr_next = wptr_reg;
    rptr_next = rptr_reg;
    cnt_next  = cnt_reg;
    err_next  = err_reg;
    if (a_hs) begin
      lock_next = 1'b0;
      rr_next   = host_wrap(gnt, 1);
      wptr_next = ptr_inc(wptr_reg);
    end else if (dev_a_valid) begin
      // Device stalled a presented request: freeze the grant so A fields stay stable.
      lock_next = 1'b1;
      gnt_next  = gnt;
    end
    if (d_pop) rptr_next = ptr_inc(rptr_reg);
    case ({a_hs, d_pop})
      2'b10:   cnt_next = cnt_reg + CntW'(1);
      2'b01:   cnt_next = cnt_reg - CntW'(1);
      default: cnt_next = cnt_reg;
    endcase
    if (fifo_empty && tl_d.d_valid[0]) err_next = 1'b1;
  end

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = rr_reg;
    // Scan from lowest priority up so the nearest valid host after rr_reg wins.
    for (int off = NumHosts - 1; off >= 0; off--) begin
      if (tl_h.a_valid[host_wrap(rr_reg, off)]) begin
        arb_found = 1'b1;
        arb_idx   = host_wrap(rr_reg, off);
      end
    end
    gnt         = lock_reg ? gnt_reg : arb_idx;
    gnt_valid   = lock_reg | arb_found;
    fifo_full   = (cnt_reg == CntW'(MaxOutstanding));
    fifo_empty  = (cnt_reg == '0);
    head        = fifo_mem[rptr_reg];
    dev_a_valid = rst_ni & gnt_valid & tl_h.a_valid[gnt] & ~fifo_full;
    dev_d_ready = rst_ni & (fifo_empty | tl_h.d_ready[head]);
    a_hs        = dev_a_valid & tl_d.a_ready[0];
    d_pop       = ~fifo_empty & tl_d.d_valid[0] & dev_d_ready;
  end

  assign tl_d.a_valid   = dev_a_valid;
  assign tl_d.a_opcode  = tl_h.a_opcode[gnt];
  assign tl_d.a_size    = tl_h.a_size[gnt];
  assign tl_d.a_source  = tl_h.a_source[gnt];
  assign tl_d.a_address = tl_h.a_address[gnt];
  assign tl_d.a_mask    = tl_h.a_mask[gnt];
  assign tl_d.a_data    = tl_h.a_data[gnt];
  assign tl_d.d_ready   = dev_d_ready;

  for (genvar gi = 0; gi < NumHosts; gi++) begin : g_host
    assign tl_h.a_ready[gi]  = rst_ni & gnt_valid & (gnt == HostIdxW'(gi))
                               & tl_d.a_ready[0] & ~fifo_full;
    assign tl_h.d_valid[gi]  = rst_ni & ~fifo_empty & (head == HostIdxW'(gi)) & tl_d.d_valid[0];
    assign tl_h.d_opcode[gi] = tl_d.d_opcode[0];
    assign tl_h.d_size[gi]   = tl_d.d_size[0];
    assign tl_h.d_source[gi] = tl_d.d_source[0];
    assign tl_h.d_data[gi]   = tl_d.d_data[0];
    assign tl_h.d_error[gi]  = tl_d.d_error[0];
  end

  assign outstanding_o   = cnt_reg;
  assign err_unexp_rsp_o = err_reg;

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Bench for tlul_host_arbiter (3 hosts, 4 outstanding): vector table, directed corner
// sequences and a randomized run, all checked against a queue-based reference model.
module tb_tlul_host_arbiter;
  localparam int NH = 3;
  localparam int MO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] outstanding;
  logic       err_unexp;

  tlul_host_arbiter_if #(.NumLanes(NH)) hbus ();
  tlul_host_arbiter_if #(.NumLanes(1))  dbus ();

  tlul_host_arbiter #(.NumHosts(NH), .MaxOutstanding(MO)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .tl_h            (hbus),
    .tl_d            (dbus),
    .outstanding_o   (outstanding),
    .err_unexp_rsp_o (err_unexp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of hosts owed a response, rr pointer, locked host (-1 = none).
  int   exp_q[$];
  int   m_rr = 0;
  int   m_lock = -1;
  int   m_gnt = 0;
  bit   m_err = 1'b0;
  bit   m_av, m_dr, m_hs;
  bit   s_rst, s_dv, s_ar;

  typedef struct {
    logic [2:0] av;
    logic       ar;
    logic       dv;
    logic [2:0] dr;
    logic       x_av;
    logic [2:0] x_ar;
    logic [2:0] x_dv;
    logic       x_dr;
    logic [2:0] x_cnt;
    logic       x_err;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(logic [2:0] av, logic ar, logic dv, logic [2:0] dr);
    hbus.a_valid     = av;
    hbus.d_ready     = dr;
    dbus.a_ready[0]  = ar;
    dbus.d_valid[0]  = dv;
    dbus.d_opcode[0] = 3'($urandom);
    dbus.d_size[0]   = 2'($urandom);
    dbus.d_source[0] = 8'($urandom);
    dbus.d_data[0]   = $urandom;
    dbus.d_error[0]  = 1'($urandom);
  endtask

  task automatic set_fixed();
    for (int i = 0; i < NH; i++) begin
      hbus.a_opcode[i]  = 3'd4;
      hbus.a_size[i]    = 2'd2;
      hbus.a_source[i]  = 8'(8'h10 + i);
      hbus.a_address[i] = 32'h4000_0000 + 32'(i * 256);
      hbus.a_mask[i]    = 4'hF;
      hbus.a_data[i]    = 32'hD000_0000 + 32'(i);
    end
  endtask

  task automatic rand_fields(int i);
    hbus.a_opcode[i]  = 3'($urandom);
    hbus.a_size[i]    = 2'($urandom);
    hbus.a_source[i]  = 8'($urandom);
    hbus.a_address[i] = $urandom;
    hbus.a_mask[i]    = 4'($urandom);
    hbus.a_data[i]    = $urandom;
  endtask

  // Compare every output against the model at the falling edge of the current cycle.
  task automatic sample();
    bit         have, full;
    int         head;
    logic [2:0] x_ar, x_dv;
    @(negedge clk);
    s_rst = rst_n;
    s_dv  = dbus.d_valid[0];
    s_ar  = dbus.a_ready[0];
    full  = (exp_q.size() == MO);
    have  = 1'b0;
    m_gnt = 0;
    if (m_lock >= 0) begin
      have  = 1'b1;
      m_gnt = m_lock;
    end else begin
      for (int k = 0; k < NH; k++) begin
        if (!have && hbus.a_valid[(m_rr + k) % NH]) begin
          have  = 1'b1;
          m_gnt = (m_rr + k) % NH;
        end
      end
    end
    m_av = s_rst && have && hbus.a_valid[m_gnt] && !full;
    x_ar = (s_rst && have && !full && s_ar) ? 3'(1 << m_gnt) : 3'b000;
    if (exp_q.size() == 0) begin
      x_dv = 3'b000;
      m_dr = s_rst;
    end else begin
      head = exp_q[0];
      x_dv = (s_rst && s_dv) ? 3'(1 << head) : 3'b000;
      m_dr = s_rst && hbus.d_ready[head];
    end
    chk("a_valid", 160'(dbus.a_valid[0]), 160'(m_av));
    if (m_av)
      chk("a_fields", {dbus.a_opcode[0], dbus.a_size[0], dbus.a_source[0], dbus.a_address[0],
                       dbus.a_mask[0], dbus.a_data[0]},
                      {hbus.a_opcode[m_gnt], hbus.a_size[m_gnt], hbus.a_source[m_gnt],
                       hbus.a_address[m_gnt], hbus.a_mask[m_gnt], hbus.a_data[m_gnt]});
    chk("a_ready", 160'(hbus.a_ready), 160'(x_ar));
    chk("d_valid", 160'(hbus.d_valid), 160'(x_dv));
    chk("d_ready", 160'(dbus.d_ready[0]), 160'(m_dr));
    chk("d_bcast", {hbus.d_opcode, hbus.d_size, hbus.d_error, hbus.d_source, hbus.d_data},
                   {{NH{dbus.d_opcode[0]}}, {NH{dbus.d_size[0]}}, {NH{dbus.d_error[0]}},
                    {NH{dbus.d_source[0]}}, {NH{dbus.d_data[0]}}});
    chk("outstanding", 160'(outstanding), 160'(exp_q.size()));
    chk("err", 160'(err_unexp), 160'(m_err));
  endtask

  // Advance the model across the rising edge, then return 1 time unit later.
  task automatic tick();
    @(posedge clk);
    m_hs = 1'b0;
    if (!s_rst) begin
      exp_q.delete();
      m_rr   = 0;
      m_lock = -1;
      m_err  = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        if (s_dv) m_err = 1'b1;
      end else if (s_dv && m_dr) begin
        void'(exp_q.pop_front());
      end
      if (m_av && s_ar) begin
        m_hs = 1'b1;
        $display("txn: host %0d source %02h addr %08h queued (%0d owed)", m_gnt,
                 hbus.a_source[m_gnt], hbus.a_address[m_gnt], exp_q.size() + 1);
        exp_q.push_back(m_gnt);
        m_rr   = (m_gnt + 1) % NH;
        m_lock = -1;
      end else if (m_av) begin
        m_lock = m_gnt;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(3'b000, 1'b0, 1'b0, 3'b000);
    sample(); tick();
    sample(); tick();
    rst_n = 1'b1;
    set_fixed();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] pend;
    //            av      ar    dv    dr      x_av  x_ar    x_dv    x_dr  x_cnt x_err
    tbl[0]  = '{3'b001, 1'b1, 1'b1, 3'b111, 1'b1, 3'b001, 3'b000, 1'b1, 3'd0, 1'b0};
    tbl[1]  = '{3'b001, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 3'd1, 1'b1};
    tbl[2]  = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0, 3'd2, 1'b1};
    tbl[3]  = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 3'd3, 1'b1};
    tbl[4]  = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 3'd4, 1'b1};
    tbl[5]  = '{3'b011, 1'b1, 1'b1, 3'b001, 1'b0, 3'b000, 3'b001, 1'b1, 3'd4, 1'b1};
    tbl[6]  = '{3'b011, 1'b1, 1'b1, 3'b000, 1'b1, 3'b010, 3'b001, 1'b0, 3'd3, 1'b1};
    tbl[7]  = '{3'b001, 1'b0, 1'b1, 3'b011, 1'b0, 3'b000, 3'b001, 1'b1, 3'd4, 1'b1};
    tbl[8]  = '{3'b001, 1'b0, 1'b1, 3'b010, 1'b1, 3'b000, 3'b010, 1'b1, 3'd3, 1'b1};
    tbl[9]  = '{3'b011, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 3'd2, 1'b1};
    tbl[10] = '{3'b000, 1'b1, 1'b1, 3'b100, 1'b0, 3'b000, 3'b001, 1'b0, 3'd3, 1'b1};
    tbl[11] = '{3'b000, 1'b1, 1'b1, 3'b111, 1'b0, 3'b000, 3'b001, 1'b1, 3'd3, 1'b1};

    drive(3'b000, 1'b0, 1'b0, 3'b000);
    set_fixed();
    do_reset();

    // Vector table: fill to full, stall, pop-then-resume, unexpected response.
    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].av, tbl[r].ar, tbl[r].dv, tbl[r].dr);
      sample();
      chk("tbl_a_valid", 160'(dbus.a_valid[0]), 160'(tbl[r].x_av));
      chk("tbl_a_ready", 160'(hbus.a_ready), 160'(tbl[r].x_ar));
      chk("tbl_d_valid", 160'(hbus.d_valid), 160'(tbl[r].x_dv));
      chk("tbl_d_ready", 160'(dbus.d_ready[0]), 160'(tbl[r].x_dr));
      chk("tbl_outstanding", 160'(outstanding), 160'(tbl[r].x_cnt));
      chk("tbl_err", 160'(err_unexp), 160'(tbl[r].x_err));
      tick();
    end

    // Round robin with all hosts requesting, responses returned in order.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(3'b111, 1'b1, (k > 0), 3'b111);
      sample();
      chk("rr_grant", 160'(dbus.a_source[0]), 160'(8'h10 + k % 3));
      if (k > 0) chk("rr_route", 160'(hbus.d_valid), 160'(1 << ((k - 1) % 3)));
      tick();
    end

    // Lock: host 1 stalled for 3 cycles while host 0 also requests.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive((k == 0) ? 3'b010 : 3'b011, (k == 3), 1'b0, 3'b000);
      sample();
      chk("lock_source", 160'(dbus.a_source[0]), 160'(8'h11));
      chk("lock_addr", 160'(dbus.a_address[0]), 160'(32'h4000_0100));
      chk("lock_a_ready", 160'(hbus.a_ready), 160'((k == 3) ? 3'b010 : 3'b000));
      tick();
    end
    drive(3'b001, 1'b1, 1'b0, 3'b000);
    sample();
    chk("lock_next_host", 160'(dbus.a_source[0]), 160'(8'h10));
    chk("lock_next_ready", 160'(hbus.a_ready), 160'(3'b001));
    tick();

    // Full FIFO: 4 accepted, stall, one response, fifth accepted the cycle after.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(3'b001, 1'b1, 1'b0, 3'b000);
      sample();
      chk("full_fill_av", 160'(dbus.a_valid[0]), 160'(1'b1));
      tick();
    end
    drive(3'b001, 1'b1, 1'b0, 3'b000);
    sample();
    chk("full_stall_av", 160'(dbus.a_valid[0]), 160'(1'b0));
    chk("full_occ", 160'(outstanding), 160'(3'd4));
    tick();
    drive(3'b001, 1'b1, 1'b1, 3'b001);
    sample();
    chk("full_pop_av", 160'(dbus.a_valid[0]), 160'(1'b0));
    tick();
    drive(3'b001, 1'b1, 1'b0, 3'b000);
    sample();
    chk("full_resume_occ", 160'(outstanding), 160'(3'd3));
    chk("full_resume_av", 160'(dbus.a_valid[0]), 160'(1'b1));
    tick();
    drive(3'b000, 1'b1, 1'b0, 3'b000);
    sample();
    chk("full_refill_occ", 160'(outstanding), 160'(3'd4));
    tick();

    // Push and pop together at occupancy 2; pointers wrap several times.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(3'b001, 1'b1, 1'b0, 3'b111);
      sample(); tick();
    end
    for (int k = 0; k < 10; k++) begin
      drive(3'b111, 1'b1, 1'b1, 3'b111);
      sample();
      chk("pp_occ", 160'(outstanding), 160'(3'd2));
      tick();
    end

    // Unexpected response on an empty FIFO: drained, not routed, sticky error.
    do_reset();
    drive(3'b000, 1'b0, 1'b1, 3'b000);
    sample();
    chk("unexp_d_ready", 160'(dbus.d_ready[0]), 160'(1'b1));
    chk("unexp_d_valid", 160'(hbus.d_valid), 160'(3'b000));
    chk("unexp_err_pre", 160'(err_unexp), 160'(1'b0));
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3'b000, 1'b0, 1'b0, 3'b000);
      sample();
      chk("unexp_err_sticky", 160'(err_unexp), 160'(1'b1));
      tick();
    end

    // Reset with 3 outstanding and the error flag set.
    for (int k = 0; k < 3; k++) begin
      drive(3'b001, 1'b1, 1'b0, 3'b000);
      sample(); tick();
    end
    rst_n = 1'b0;
    drive(3'b111, 1'b1, 1'b1, 3'b111);
    sample();
    chk("rst_a_valid", 160'(dbus.a_valid[0]), 160'(1'b0));
    chk("rst_a_ready", 160'(hbus.a_ready), 160'(3'b000));
    chk("rst_d_valid", 160'(hbus.d_valid), 160'(3'b000));
    chk("rst_d_ready", 160'(dbus.d_ready[0]), 160'(1'b0));
    chk("rst_occ_pre", 160'(outstanding), 160'(3'd3));
    tick();
    sample();
    chk("rst_occ", 160'(outstanding), 160'(3'd0));
    chk("rst_err", 160'(err_unexp), 160'(1'b0));
    tick();
    rst_n = 1'b1;
    drive(3'b000, 1'b0, 1'b1, 3'b000);
    sample(); tick();
    drive(3'b000, 1'b0, 1'b0, 3'b000);
    sample();
    chk("rst_late_rsp_err", 160'(err_unexp), 160'(1'b1));
    tick();

    // Randomized traffic; hosts hold a request and its fields until accepted.
    do_reset();
    pend = 3'b000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NH; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
          pend[i] = 1'b1;
          rand_fields(i);
        end
      end
      drive(pend, ($urandom_range(0, 3) != 0), (exp_q.size() > 0) && ($urandom_range(0, 1) == 1),
            3'($urandom));
      sample();
      tick();
      if (m_hs) pend[m_gnt] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
